// File: rtl/mem_access_ctl_if.sv
// Data-memory request/response bus between the MEM-stage controller and the
// multi-cycle data memory.
interface mem_access_ctl_if;
    logic        dmem_en;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_done;
    logic [15:0] dmem_rdata;

    // Controller side: issues requests, consumes completion and read data.
    modport master (
        output dmem_en, dmem_wr, dmem_addr, dmem_wdata,
        input  dmem_done, dmem_rdata
    );

    // Memory side: accepts requests, returns completion and read data.
    modport slave (
        input  dmem_en, dmem_wr, dmem_addr, dmem_wdata,
        output dmem_done, dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctl.sv
// MEM-stage access controller: runs one handshaked transaction per load/store
// against a multi-cycle data memory, stalls the pipeline while it is
// outstanding, returns load data, and latches unaligned/timeout faults.
module mem_access_ctl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic [15:0]             addr,
    input  logic [15:0]             wrtData,
    mem_access_ctl_if.master        dmem,
    output logic [15:0]             memData,
    output logic                    mem_stall,
    output logic                    valid_out,
    output logic                    err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc;

    assign acc = valid_in & (memRead | memWrite);

    // Transaction FSM with registered request, load-data and fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            dmem.dmem_en    <= 1'b0;
            dmem.dmem_wr    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            memData         <= '0;
            err             <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (!addr[0]) begin
                            dmem.dmem_en    <= 1'b1;
                            dmem.dmem_wr    <= memWrite;
                            dmem.dmem_addr  <= addr;
                            dmem.dmem_wdata <= wrtData;
                            state           <= REQ;
                        end else begin
                            // Unaligned: fault without touching the memory bus.
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                REQ: begin
                    // Strobe lasts exactly this one cycle; done cannot arrive yet.
                    dmem.dmem_en <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (dmem.dmem_done) begin
                        if (!dmem.dmem_wr) begin
                            memData <= dmem.dmem_rdata;
                        end
                        state <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                ERR: begin
                    dmem.dmem_en <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline handshake: stall while a transaction is pending, complete on RESP.
    always_comb begin
        mem_stall = 1'b0;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = acc;
                valid_out = valid_in & ~acc;
            end
            REQ, WAIT, ERR: begin
                mem_stall = 1'b1;
            end
            RESP: begin
                valid_out = 1'b1;
            end
            default: begin
                mem_stall = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Directed bench for mem_access_ctl: a per-cycle vector table for loads,
// stores, pass-through, back-to-back loads and timeout, plus hand-written
// sequences for unaligned faults and asynchronous reset.
module tb_mem_access_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        memRead;
    logic        memWrite;
    logic [15:0] addr;
    logic [15:0] wrtData;
    logic [15:0] memData;
    logic        mem_stall;
    logic        valid_out;
    logic        err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned en_pulses = 0;

    mem_access_ctl_if dbus();

    mem_access_ctl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .wrtData   (wrtData),
        .dmem      (dbus),
        .memData   (memData),
        .mem_stall (mem_stall),
        .valid_out (valid_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Observed outputs: {en, wr, addr, wdata, memData, stall, valid_out, err}
    logic [52:0] obs;
    assign obs = {dbus.dmem_en, dbus.dmem_wr, dbus.dmem_addr, dbus.dmem_wdata,
                  memData, mem_stall, valid_out, err};

    // Count request strobes as seen by the memory at each clock edge.
    always @(posedge clk) begin
        if (!rst && dbus.dmem_en) en_pulses++;
    end

    typedef struct packed {
        logic        vin;
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic        done;
        logic [15:0] rdata;
        logic [52:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic vin, rd, wr,
                               input logic [15:0] a, wd,
                               input logic done, input logic [15:0] rdata,
                               input logic en, dwr,
                               input logic [15:0] da, dwd, md,
                               input logic st, vo, er);
        vec_t r;
        r.vin = vin; r.rd = rd; r.wr = wr; r.a = a; r.wd = wd;
        r.done = done; r.rdata = rdata;
        r.exp = {en, dwr, da, dwd, md, st, vo, er};
        return r;
    endfunction

    task automatic check(input string name, input logic [52:0] act, input logic [52:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vin, rd, wr, input logic [15:0] a, wd);
        valid_in = vin; memRead = rd; memWrite = wr; addr = a; wrtData = wd;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 16'h0000, 16'h0000);
        dbus.dmem_done  = 1'b0;
        dbus.dmem_rdata = 16'h0000;

        //        vin rd wr addr     wdata    dn rdata    | en wr daddr    dwdata   memData  st vo er
        // Load 0x0010, done 2 cycles after strobe
        vecs.push_back(v(1,1,0,16'h0010,16'h5555,0,16'h0000, 0,0,16'h0000,16'h0000,16'h0000,1,0,0));
        vecs.push_back(v(1,1,0,16'h0010,16'h5555,0,16'h0000, 1,0,16'h0010,16'h5555,16'h0000,1,0,0));
        vecs.push_back(v(1,1,0,16'h0010,16'h5555,0,16'h0000, 0,0,16'h0010,16'h5555,16'h0000,1,0,0));
        vecs.push_back(v(1,1,0,16'h0010,16'h5555,1,16'hBEEF, 0,0,16'h0010,16'h5555,16'h0000,1,0,0));
        vecs.push_back(v(1,1,0,16'h0010,16'h5555,0,16'h0000, 0,0,16'h0010,16'h5555,16'hBEEF,0,1,0));
        // Store 0x0022 <- 0x1234, done 1 cycle after strobe; rdata must be ignored
        vecs.push_back(v(1,0,1,16'h0022,16'h1234,0,16'h0000, 0,0,16'h0010,16'h5555,16'hBEEF,1,0,0));
        vecs.push_back(v(1,0,1,16'h0022,16'h1234,0,16'h0000, 1,1,16'h0022,16'h1234,16'hBEEF,1,0,0));
        vecs.push_back(v(1,0,1,16'h0022,16'h1234,1,16'hDEAD, 0,1,16'h0022,16'h1234,16'hBEEF,1,0,0));
        vecs.push_back(v(1,0,1,16'h0022,16'h1234,0,16'h0000, 0,1,16'h0022,16'h1234,16'hBEEF,0,1,0));
        // Non-memory pass-through (stray done in IDLE ignored), then an invalid slot
        vecs.push_back(v(1,0,0,16'h0100,16'hFFFF,0,16'h0000, 0,1,16'h0022,16'h1234,16'hBEEF,0,1,0));
        vecs.push_back(v(1,0,0,16'h0100,16'hFFFF,1,16'h1111, 0,1,16'h0022,16'h1234,16'hBEEF,0,1,0));
        vecs.push_back(v(1,0,0,16'h0100,16'hFFFF,0,16'h0000, 0,1,16'h0022,16'h1234,16'hBEEF,0,1,0));
        vecs.push_back(v(0,1,0,16'h0004,16'h0000,0,16'h0000, 0,1,16'h0022,16'h1234,16'hBEEF,0,0,0));
        // Back-to-back loads 0x0004 then 0x0006, latency 1
        vecs.push_back(v(1,1,0,16'h0004,16'h0000,0,16'h0000, 0,1,16'h0022,16'h1234,16'hBEEF,1,0,0));
        vecs.push_back(v(1,1,0,16'h0004,16'h0000,0,16'h0000, 1,0,16'h0004,16'h0000,16'hBEEF,1,0,0));
        vecs.push_back(v(1,1,0,16'h0004,16'h0000,1,16'h0A0A, 0,0,16'h0004,16'h0000,16'hBEEF,1,0,0));
        vecs.push_back(v(1,1,0,16'h0004,16'h0000,0,16'h0000, 0,0,16'h0004,16'h0000,16'h0A0A,0,1,0));
        vecs.push_back(v(1,1,0,16'h0006,16'h0000,0,16'h0000, 0,0,16'h0004,16'h0000,16'h0A0A,1,0,0));
        vecs.push_back(v(1,1,0,16'h0006,16'h0000,0,16'h0000, 1,0,16'h0006,16'h0000,16'h0A0A,1,0,0));
        vecs.push_back(v(1,1,0,16'h0006,16'h0000,1,16'h0B0B, 0,0,16'h0006,16'h0000,16'h0A0A,1,0,0));
        vecs.push_back(v(1,1,0,16'h0006,16'h0000,0,16'h0000, 0,0,16'h0006,16'h0000,16'h0B0B,0,1,0));
        // Timeout (TIMEOUT=4): four WAIT cycles without done, then sticky ERR
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0006,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 1,0,16'h0008,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,0));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,1));
        vecs.push_back(v(1,1,0,16'h0008,16'h0000,1,16'hFFFF, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,1));
        vecs.push_back(v(0,0,0,16'h0000,16'h0000,0,16'h0000, 0,0,16'h0008,16'h0000,16'h0B0B,1,0,1));

        // Reset state
        @(negedge clk);
        check("reset_state", obs, 53'd0);
        rst = 1'b0;

        // Table-driven per-cycle vectors: drive after the edge, check mid-cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].vin, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
            dbus.dmem_done  = vecs[i].done;
            dbus.dmem_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end
        dbus.dmem_done = 1'b0;
        check("strobe_count", {21'd0, en_pulses}, 53'd5);

        // Asynchronous reset out of the timeout ERR state
        #2 rst = 1'b1;
        #1 check("err_clear_after_timeout", obs, 53'd0);
        #1 rst = 1'b0;

        // Unaligned load: no strobe, sticky error, permanent stall
        @(posedge clk);
        #1 drive(1, 1, 0, 16'h0003, 16'h0000);
        @(negedge clk);
        check("unaligned_idle_stall", {51'd0, dbus.dmem_en, mem_stall}, 53'd1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("unaligned_err_c%0d", c),
                  {49'd0, dbus.dmem_en, mem_stall, valid_out, err}, 53'b0101);
        end
        #2 drive(0, 0, 0, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1 check("unaligned_rst_clear", {51'd0, err, mem_stall}, 53'd0);
        #1 rst = 1'b0;

        // Asynchronous reset in WAIT, then a late done must be ignored
        @(posedge clk);
        #1 drive(1, 1, 0, 16'h0040, 16'h0000);
        @(posedge clk);   // enters REQ
        @(posedge clk);   // enters WAIT
        #2 check("wait_stall", {51'd0, mem_stall, valid_out}, 53'b10);
        drive(0, 0, 0, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1 check("wait_rst_idle", {50'd0, dbus.dmem_en, mem_stall, valid_out}, 53'd0);
        #1 rst = 1'b0;
        dbus.dmem_done  = 1'b1;
        dbus.dmem_rdata = 16'h7777;
        @(posedge clk);
        #1 dbus.dmem_done = 1'b0;
        drive(1, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("late_done_ignored",
              {34'd0, dbus.dmem_en, memData, mem_stall, valid_out}, {34'd0, 1'b0, 16'h0000, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctl.md
Name: mem_access_ctl

Overview:
- Memory-stage access controller, directly downstream of the execute stage.
- Consumes the execute result as address (aluFinal) and the forwarded store data (wrtDataXout), and runs one handshaked transaction per load/store against a multi-cycle data memory.
- Stalls the pipeline while a transaction is outstanding and returns load data to writeback.
- Flags unaligned accesses and memory timeouts as a sticky error.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before error (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset
valid_in  in  1  instruction in MEM slot is valid
memRead  in  1  load
memWrite  in  1  store (memRead and memWrite never both 1)
addr  in  16  effective address (execute aluFinal)
wrtData  in  16  store data (execute wrtDataXout)
dmem_en  out  1  memory request strobe, registered
dmem_wr  out  1  1=write, registered
dmem_addr  out  16  request address, registered
dmem_wdata  out  16  request write data, registered
dmem_done  in  1  one-cycle completion pulse from memory
dmem_rdata  in  16  read data, valid when dmem_done=1
memData  out  16  last load data, registered
mem_stall  out  1  hold upstream stages and this slot's inputs
valid_out  out  1  instruction completes MEM this cycle
err  out  1  sticky fault flag

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, dmem_en=0, dmem_wr=0, dmem_addr=0, dmem_wdata=0, memData=0, err=0, wait counter=0.
- Let acc = valid_in & (memRead | memWrite).
- States: IDLE, REQ, WAIT, RESP, ERR.
- IDLE:
  - acc & addr[0]=0: latch addr/wrtData/memWrite into dmem_* registers, dmem_en<=1, go REQ. mem_stall=1 combinationally this cycle.
  - acc & addr[0]=1 (unaligned): err<=1, go ERR, no request issued.
  - ~acc: mem_stall=0, valid_out=valid_in (pass-through, zero latency).
- REQ:
  - dmem_en=1 for exactly this one cycle; dmem_en<=0 at exit, go WAIT, counter<=0.
  - mem_stall=1.
  - dmem_done is ignored here; memory guarantees latency >=1 cycle after the strobe.
- WAIT:
  - mem_stall=1.
  - dmem_done=1: if read, memData<=dmem_rdata; go RESP.
  - Else counter increments. Counter reaching TIMEOUT-1 without done: err<=1, go ERR.
  - done in the same cycle as timeout: done wins.
- RESP:
  - mem_stall=0, valid_out=1, memData holds the loaded value; go IDLE.
  - Upstream advances at this edge, so the same instruction is never re-issued.
- ERR: mem_stall=1 and valid_out=0 forever; dmem_en=0; exit only by reset.
- Outputs:
  - valid_out=0 in REQ/WAIT.
  - memData is unchanged by stores and non-memory instructions.
  - dmem_addr/dmem_wdata/dmem_wr hold their values after the strobe until the next request.
- Inputs are stable while mem_stall=1 (upstream contract). Input changes in REQ/WAIT are ignored.
- Reset mid-transaction: returns to IDLE immediately. The outstanding request is abandoned and any later dmem_done is ignored in IDLE.
- Total load/store latency: 1 (IDLE) + 1 (REQ) + N (WAIT, N>=1) + 1 (RESP) cycles.

Test Plan:
- Load, memory latency 2: valid_in=1, memRead=1, addr=0x0010. Memory pulses dmem_done with rdata=0xBEEF 2 cycles after the strobe. Required: dmem_en high exactly 1 cycle with dmem_addr=0x0010 and dmem_wr=0; mem_stall high 4 cycles; valid_out=1 in the RESP cycle; memData=0xBEEF.
- Store: memWrite=1, addr=0x0022, wrtData=0x1234, done after 1 cycle. Required: dmem_wr=1, dmem_wdata=0x1234, dmem_en single pulse; memData keeps its prior value; valid_out=1 once.
- Non-memory pass-through: valid_in=1, memRead=memWrite=0 for 3 cycles. Required: mem_stall=0, valid_out=1 each cycle, dmem_en never asserted.
- Back-to-back loads to 0x0004 then 0x0006 (done latency 1): exactly two dmem_en pulses with addresses 0x0004 then 0x0006; no duplicate request for the first load.
- Unaligned load at addr=0x0003: no dmem_en; err=1 next cycle; mem_stall stays 1 for 10+ cycles. Asserting rst clears err=0 and mem_stall=0.
- Timeout with TIMEOUT=4 and dmem_done never asserted: err=1 after 4 WAIT cycles. Separately, rst asserted asynchronously in WAIT: state is IDLE and dmem_en=0 before the next clk edge, and a late dmem_done leaves memData unchanged.
